frame_source_mux: RTL



---
 rtl/frame_mux_pkg.sv | 17 +
 rtl/frame_source_mux_if.sv | 35 +++
 rtl/frame_mux_req_pipe.sv | 29 ++
 rtl/frame_source_mux.sv | 94 +++++++++
 4 files changed

// File: rtl/frame_mux_pkg.sv
// frame_mux_pkg: shared helpers, request-pipeline entry type and blank-pixel default for frame_source_mux
package frame_mux_pkg;

    localparam int TAG_W = 3;
    localparam logic [63:0] BLANK_DEFAULT = '1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             blank;
    } pipe_entry_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_source_mux_if.sv
// frame_source_mux_if: display request, channel select and RAM port signals of frame_source_mux
interface frame_source_mux_if
    import frame_mux_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic                     frame_start;
    logic                     disp_req;
    logic [ADDR_W-1:0]        disp_addr;
    logic [11:0]              pix_x;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*ADDR_W-1:0] eng_addr;
    logic [NUM_CH*ADDR_W-1:0] bram_addr;
    logic [NUM_CH*DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0]        pix_out;
    logic                     pix_valid;
    logic [SEL_W-1:0]         active_ch;
    logic                     sel_err;

    modport master (
        output frame_start, disp_req, disp_addr, pix_x, sel, ch_ready, eng_addr, bram_dout,
        input  bram_addr, pix_out, pix_valid, active_ch, sel_err
    );

    modport slave (
        input  frame_start, disp_req, disp_addr, pix_x, sel, ch_ready, eng_addr, bram_dout,
        output bram_addr, pix_out, pix_valid, active_ch, sel_err
    );

endinterface

// File: rtl/frame_mux_req_pipe.sv
// frame_mux_req_pipe: DEPTH-stage delay line of request entries with synchronous clear
module frame_mux_req_pipe
    import frame_mux_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  pipe_entry_t din,
    output pipe_entry_t dout
);

    pipe_entry_t stage_q [DEPTH];
    pipe_entry_t stage_d [DEPTH];

    // Shift entries one stage per cycle
    always_comb begin
        stage_d[0] = din;
        for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    end

    // Stage registers; reset drops every in-flight request
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) stage_q[k] <= rst ? '0 : stage_d[k];
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_source_mux.sv
// frame_source_mux: per-frame display channel selector with RAM port arbitration and read-data alignment.
// Optional: define SPLIT_VIEW_EN for split-screen compare (columns left of SPLIT_COL show channel 0).
module frame_source_mux
    import frame_mux_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 8,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] BLANK_VAL = BLANK_DEFAULT[DATA_W-1:0],
    parameter int                SPLIT_COL = 320
) (
    input logic               clk,
    input logic               rst,
    frame_source_mux_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic [SEL_W-1:0]         active_ch_q, active_ch_d, req_ch;
    logic                     sel_ok, sel_err_q, sel_err_d;
    logic [NUM_CH*ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]        pix_out_q, pix_out_d, dout_sel;
    logic                     pix_valid_q, pix_valid_d;
    pipe_entry_t              req_in, req_out;

    assign sel_ok = int'(bus.sel) < NUM_CH;

`ifndef SPLIT_VIEW_EN
    logic unused_pix_x;
    assign unused_pix_x = ^bus.pix_x;
`endif

    // Latch the channel at frame start; a request in the same cycle sees the new channel via bypass
    always_comb begin
        active_ch_d = (bus.frame_start && sel_ok) ? bus.sel : active_ch_q;
        sel_err_d   = bus.frame_start && !sel_ok;
`ifdef SPLIT_VIEW_EN
        req_ch = (int'(bus.pix_x) < SPLIT_COL) ? '0 : (active_ch_d == '0) ? SEL_W'(1) : active_ch_d;
`else
        req_ch = active_ch_d;
`endif
        req_in.valid = bus.disp_req;
        req_in.tag   = TAG_W'(req_ch);
        req_in.blank = !bus.ch_ready[req_ch];
    end

    // Each RAM port belongs to its engine until that channel's processing is complete
    always_comb begin
        bram_addr_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            bram_addr_d[i*ADDR_W +: ADDR_W] = bus.ch_ready[i] ? bus.disp_addr : bus.eng_addr[i*ADDR_W +: ADDR_W];
    end

    frame_mux_req_pipe #(.DEPTH(RD_LAT + 1)) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (req_in),
        .dout (req_out)
    );

    // Pick the tagged channel's read data as it arrives; hold the pixel between requests
    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (req_out.tag == TAG_W'(i)) dout_sel = bus.bram_dout[i*DATA_W +: DATA_W];
        pix_valid_d = req_out.valid;
        pix_out_d   = !req_out.valid ? pix_out_q : req_out.blank ? BLANK_VAL : dout_sel;
    end

    // Output and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active_ch_q <= '0;
            sel_err_q   <= 1'b0;
            bram_addr_q <= '0;
            pix_out_q   <= BLANK_VAL;
            pix_valid_q <= 1'b0;
        end else begin
            active_ch_q <= active_ch_d;
            sel_err_q   <= sel_err_d;
            bram_addr_q <= bram_addr_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign bus.bram_addr = bram_addr_q;
    assign bus.pix_out   = pix_out_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.active_ch = active_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule
